// File: rtl/mixer_pkg.sv
// Shared types and helpers for the layer mixer: colour structs, fade state
// encoding and the 8-to-10 bit colour expansion.
package mixer_pkg;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic [7:0] a;
  } rgba_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FADE_OUT = 2'd1,
    BLACK    = 2'd2,
    FADE_IN  = 2'd3
  } fade_state_t;

  localparam logic [8:0] FADE_FULL = 9'd256;

  // Replicating the top bits keeps full-scale white at full-scale on the DAC.
  function automatic logic [9:0] expand8to10(input logic [7:0] c);
    return {c, c[7:6]};
  endfunction

endpackage

// File: rtl/layer_mixer_if.sv
// Pixel-side and DAC-side signal bundle of the layer mixer.
interface layer_mixer_if #(
  parameter int NSPR = 2
);

  logic                   active;
  logic                   hsync_in;
  logic                   vsync_in;
  logic                   frame_start;
  logic [23:0]            bck_rgb;
  logic [32*NSPR-1:0]     spr_rgba;
  logic [1:0]             fade_cmd;
  logic [9:0]             vga_r;
  logic [9:0]             vga_g;
  logic [9:0]             vga_b;
  logic                   vga_hs;
  logic                   vga_vs;
  logic                   vga_blank;
  logic                   fade_busy;

  modport master (
    output active, hsync_in, vsync_in, frame_start, bck_rgb, spr_rgba, fade_cmd,
    input  vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_blank, fade_busy
  );

  modport slave (
    input  active, hsync_in, vsync_in, frame_start, bck_rgb, spr_rgba, fade_cmd,
    output vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_blank, fade_busy
  );

endinterface

// File: rtl/alpha_blend_stage.sv
// One registered pipeline stage that blends an RGBA layer over the colour
// coming up from the layers beneath it.
module alpha_blend_stage
  import mixer_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  rgb_t  dst,
  input  rgba_t src,
  output rgb_t  mix
);

  logic [8:0] alpha;

  // Remapping 255 to 256 makes an opaque sprite reproduce its colour exactly.
  function automatic logic [7:0] blend_ch(input logic [8:0] a,
                                          input logic [7:0] s,
                                          input logic [7:0] d);
    logic [16:0] acc;
    acc = 17'(a) * 17'(s) + 17'(FADE_FULL - a) * 17'(d);
    return acc[15:8];
  endfunction

  always_comb begin
    alpha = {1'b0, src.a} + 9'(src.a[7]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mix <= '0;
    end else begin
      mix.r <= blend_ch(alpha, src.r, dst.r);
      mix.g <= blend_ch(alpha, src.g, dst.g);
      mix.b <= blend_ch(alpha, src.b, dst.b);
    end
  end

endmodule

// File: rtl/layer_mixer.sv
// Pipelined compositor: background plus NSPR alpha-blended sprite layers,
// frame-synchronous global fade and 10-bit expansion, sync kept aligned.
module layer_mixer
  import mixer_pkg::*;
#(
  parameter int NSPR      = 2,
  parameter int FADE_STEP = 16
) (
  input logic           clk,
  input logic           reset,
  layer_mixer_if.slave  bus
);

  localparam logic [8:0] STEP = 9'(FADE_STEP);

  fade_state_t        state;
  fade_state_t        state_nxt;
  fade_state_t        fade_dir;
  logic [8:0]         level;
  logic [8:0]         level_nxt;

  rgb_t               bck_q;
  rgb_t               col [NSPR+1];
  logic [32*NSPR-1:0] spr_q [NSPR];
  logic [2:0]         side_q [NSPR+1];

  logic [9:0]         r_q;
  logic [9:0]         g_q;
  logic [9:0]         b_q;
  logic               hs_q;
  logic               vs_q;
  logic               blank_q;
  logic               busy;

  function automatic logic [7:0] fade_ch(input logic [7:0] c, input logic [8:0] l);
    logic [16:0] prod;
    prod = 17'(c) * 17'(l);
    return prod[15:8];
  endfunction

  // Stage 0 plus the delay lines that keep each sprite and the sideband
  // {active, hsync, vsync} in step with the blend stage that needs them.
  always_ff @(posedge clk) begin
    if (reset) begin
      bck_q <= '0;
      for (int k = 0; k < NSPR; k++) spr_q[k] <= '0;
      for (int k = 0; k <= NSPR; k++) side_q[k] <= '0;
    end else begin
      bck_q     <= rgb_t'(bus.bck_rgb);
      spr_q[0]  <= bus.spr_rgba;
      side_q[0] <= {bus.active, bus.hsync_in, bus.vsync_in};
      for (int k = 1; k < NSPR; k++) spr_q[k] <= spr_q[k-1];
      for (int k = 1; k <= NSPR; k++) side_q[k] <= side_q[k-1];
    end
  end

  assign col[0] = bck_q;

  // Stage k blends layer NSPR-k, so layer 0 lands on top last.
  for (genvar k = 1; k <= NSPR; k++) begin : g_blend
    alpha_blend_stage u_stage (
      .clk   (clk),
      .reset (reset),
      .dst   (col[k-1]),
      .src   (rgba_t'(spr_q[k-1][32*(NSPR-k) +: 32])),
      .mix   (col[k])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_q     <= '0;
      g_q     <= '0;
      b_q     <= '0;
      hs_q    <= 1'b0;
      vs_q    <= 1'b0;
      blank_q <= 1'b0;
    end else begin
      blank_q <= side_q[NSPR][2];
      hs_q    <= side_q[NSPR][1];
      vs_q    <= side_q[NSPR][0];
      if (side_q[NSPR][2]) begin
        r_q <= expand8to10(fade_ch(col[NSPR].r, level));
        g_q <= expand8to10(fade_ch(col[NSPR].g, level));
        b_q <= expand8to10(fade_ch(col[NSPR].b, level));
      end else begin
        r_q <= '0;
        g_q <= '0;
        b_q <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      level <= FADE_FULL;
    end else begin
      state <= state_nxt;
      level <= level_nxt;
    end
  end

  // A command redirects first, then any frame_start steps in the new direction.
  always_comb begin
    fade_dir  = state;
    state_nxt = state;
    level_nxt = level;
    case (state)
      IDLE:     if (bus.fade_cmd == 2'b01) fade_dir = FADE_OUT;
      FADE_OUT: if (bus.fade_cmd == 2'b10) fade_dir = FADE_IN;
      BLACK:    if (bus.fade_cmd == 2'b10) fade_dir = FADE_IN;
      FADE_IN:  if (bus.fade_cmd == 2'b01) fade_dir = FADE_OUT;
      default:  fade_dir = IDLE;
    endcase
    if (bus.frame_start) begin
      if (fade_dir == FADE_OUT) begin
        level_nxt = (level > STEP) ? level - STEP : 9'd0;
      end else if (fade_dir == FADE_IN) begin
        level_nxt = ((10'(level) + 10'(STEP)) >= 10'(FADE_FULL)) ? FADE_FULL : level + STEP;
      end
    end
    state_nxt = fade_dir;
    if (fade_dir == FADE_OUT && level_nxt == 9'd0) state_nxt = BLACK;
    if (fade_dir == FADE_IN && level_nxt == FADE_FULL) state_nxt = IDLE;
  end

  always_comb begin
    busy = (state == FADE_OUT) || (state == FADE_IN);
  end

  assign bus.vga_r     = r_q;
  assign bus.vga_g     = g_q;
  assign bus.vga_b     = b_q;
  assign bus.vga_hs    = hs_q;
  assign bus.vga_vs    = vs_q;
  assign bus.vga_blank = blank_q;
  assign bus.fade_busy = busy;

endmodule
